// File: rtl/video_pkg.sv
// Shared raster constants and pixel types for the video output path.
// Defaults describe 1080p60; every block takes them as overridable parameters.
package video_pkg;

  localparam int unsigned T1080_H_ACTIVE = 1920;
  localparam int unsigned T1080_H_FP     = 88;
  localparam int unsigned T1080_H_SYNC   = 44;
  localparam int unsigned T1080_H_BP     = 148;
  localparam int unsigned T1080_V_ACTIVE = 1080;
  localparam int unsigned T1080_V_FP     = 4;
  localparam int unsigned T1080_V_SYNC   = 5;
  localparam int unsigned T1080_V_BP     = 36;

  localparam int unsigned T1080_H_TOTAL =
    T1080_H_ACTIVE + T1080_H_FP + T1080_H_SYNC + T1080_H_BP;
  localparam int unsigned T1080_V_TOTAL =
    T1080_V_ACTIVE + T1080_V_FP + T1080_V_SYNC + T1080_V_BP;

  localparam int unsigned COL_W = 12;
  localparam int unsigned ROW_W = 11;
  localparam int unsigned RGB_W = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/sync_delay.sv
// WIDTH x DEPTH shift register with synchronous clear; DEPTH must be at least 1.
module sync_delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] stage;

  if (DEPTH == 1) begin : g_single
    always_ff @(posedge clock) begin
      if (reset) stage[0] <= '0;
      else       stage[0] <= din;
    end
  end else begin : g_chain
    always_ff @(posedge clock) begin
      if (reset) stage <= '0;
      else       stage <= {stage[DEPTH-2:0], din};
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/video_timing.sv
// Raster counter plus output stage: sync/DE are delayed to meet the returning
// pixel colour, then everything is registered together onto the output pins.
module video_timing
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = T1080_H_ACTIVE,
  parameter int unsigned H_FP     = T1080_H_FP,
  parameter int unsigned H_SYNC   = T1080_H_SYNC,
  parameter int unsigned H_BP     = T1080_H_BP,
  parameter int unsigned V_ACTIVE = T1080_V_ACTIVE,
  parameter int unsigned V_FP     = T1080_V_FP,
  parameter int unsigned V_SYNC   = T1080_V_SYNC,
  parameter int unsigned V_BP     = T1080_V_BP,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned PIPE_LAT = 5
) (
  input  logic             clock,
  input  logic             reset,
  output logic [COL_W-1:0] display_col,
  output logic [ROW_W-1:0] display_row,
  input  rgb_t             color,
  output rgb_t             pix_rgb,
  output logic             pix_de,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic       de_raw_c;
  logic       hs_raw_c;
  logic       vs_raw_c;
  logic [2:0] phase_d;

  // Raster counters; display_col/display_row are the counter registers themselves.
  always_ff @(posedge clock) begin
    if (reset) begin
      display_col <= '0;
      display_row <= '0;
    end else if (display_col == COL_W'(H_TOTAL - 1)) begin
      display_col <= '0;
      if (display_row == ROW_W'(V_TOTAL - 1)) display_row <= '0;
      else                                    display_row <= display_row + ROW_W'(1);
    end else begin
      display_col <= display_col + COL_W'(1);
    end
  end

  always_comb begin
    de_raw_c = (display_col < COL_W'(H_ACTIVE)) && (display_row < ROW_W'(V_ACTIVE));
    hs_raw_c = (display_col >= COL_W'(HS_START)) && (display_col < COL_W'(HS_END));
    vs_raw_c = (display_row >= ROW_W'(VS_START)) && (display_row < ROW_W'(VS_END));
  end

  // Start-of-frame marker follows the counters directly and is held low in reset.
  assign frame_start = !reset && (display_col == '0) && (display_row == '0);

  sync_delay #(
    .WIDTH(3),
    .DEPTH(PIPE_LAT)
  ) u_sync_delay (
    .clock(clock),
    .reset(reset),
    .din  ({vs_raw_c, hs_raw_c, de_raw_c}),
    .dout (phase_d)
  );

  // Output stage: colour is captured on the same edge as its delayed phase bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      pix_de  <= 1'b0;
      pix_rgb <= '0;
      hsync   <= ~HS_POL;
      vsync   <= ~VS_POL;
    end else begin
      pix_de  <= phase_d[0];
      pix_rgb <= phase_d[0] ? color : rgb_t'(RGB_W'(0));
      hsync   <= phase_d[1] ? HS_POL : ~HS_POL;
      vsync   <= phase_d[2] ? VS_POL : ~VS_POL;
    end
  end

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: a full-size 1080p instance over a few lines and a
// shrunken-raster instance over several frames, both against an arithmetic model.
module tb_video_timing;
  import video_pkg::*;

  localparam int A_HT    = 2200;
  localparam int A_LAT   = 5;
  localparam int B_FRAME = 58 * 21;
  localparam int B_LAT   = 3;
  localparam int A_RST_K = 2 * A_HT + 1000;
  localparam int B_RST_K = 3 * B_FRAME + 7 * 58 + 20;
  localparam int N_CYC   = 10500;

  typedef struct {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, lat;
  } tcfg_t;

  typedef struct {
    int col, row;
    bit fs, de, hs, vs;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_a, reset_b;
  logic [23:0] color_a, color_b, rgb_a, rgb_b;
  logic [11:0] col_a, col_b;
  logic [10:0] row_a, row_b;
  logic        de_a, hs_a, vs_a, fs_a;
  logic        de_b, hs_b, vs_b, fs_b;
  int          total = 0;
  int          bad   = 0;

  always #5 clock = ~clock;

  video_timing dut_a (
    .clock(clock), .reset(reset_a), .display_col(col_a), .display_row(row_a),
    .color(color_a), .pix_rgb(rgb_a), .pix_de(de_a), .hsync(hs_a), .vsync(vs_a),
    .frame_start(fs_a)
  );

  video_timing #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(8),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(4),
    .HS_POL(1'b0), .VS_POL(1'b1), .PIPE_LAT(B_LAT)
  ) dut_b (
    .clock(clock), .reset(reset_b), .display_col(col_b), .display_row(row_b),
    .color(color_b), .pix_rgb(rgb_b), .pix_de(de_b), .hsync(hs_b), .vsync(vs_b),
    .frame_start(fs_b)
  );

  // Expected state k cycles after reset release, straight from the raster rules.
  function automatic exp_t model(input int k, input tcfg_t c, input bit rst);
    exp_t e;
    int ht, vt, j, h, v;
    ht = c.ha + c.hfp + c.hsw + c.hbp;
    vt = c.va + c.vfp + c.vsw + c.vbp;
    e.col = k % ht;
    e.row = (k / ht) % vt;
    e.fs  = ((k % (ht * vt)) == 0) && !rst;
    j = k - c.lat - 1;
    if (j < 0) begin
      e.de = 1'b0; e.hs = 1'b0; e.vs = 1'b0;
    end else begin
      h = j % ht;
      v = (j / ht) % vt;
      e.de = (h < c.ha) && (v < c.va);
      e.hs = (h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hsw);
      e.vs = (v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vsw);
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  initial begin
    tcfg_t       cfg_a, cfg_b;
    exp_t        ea, eb;
    int          ka, kb, red, b_de_cnt, b_vs_cnt;
    bit          a_rst_done, b_rst_done;
    logic [23:0] prev_a, prev_b;

    cfg_a = '{1920, 88, 44, 148, 1080, 4, 5, 36, A_LAT};
    cfg_b = '{40, 4, 6, 8, 12, 2, 3, 4, B_LAT};
    reset_a = 1'b1; reset_b = 1'b1;
    color_a = '0;   color_b = '0;
    prev_a  = '0;   prev_b  = '0;
    a_rst_done = 1'b0; b_rst_done = 1'b0;
    b_de_cnt = 0; b_vs_cnt = 0;

    // Reset held for three clocks: outputs sit at their inactive levels.
    repeat (3) begin
      @(posedge clock); #1;
      chk("a_rst_de",  32'(de_a), 32'(0));
      chk("a_rst_hs",  32'(hs_a), 32'(0));
      chk("a_rst_vs",  32'(vs_a), 32'(0));
      chk("a_rst_rgb", 32'(rgb_a), 32'(0));
      chk("a_rst_fs",  32'(fs_a), 32'(0));
      chk("b_rst_hs",  32'(hs_b), 32'(1));
      chk("b_rst_vs",  32'(vs_b), 32'(0));
      chk("b_rst_de",  32'(de_b), 32'(0));
    end

    ka = 0; kb = 0;
    for (int n = 0; n < N_CYC; n++) begin
      reset_a = (ka == A_RST_K) && !a_rst_done;
      reset_b = (kb == B_RST_K) && !b_rst_done;
      red     = (ka >= A_LAT) ? ((ka - A_LAT) % A_HT) % 256 : 0;
      color_a = {8'(red), 16'($urandom)};
      color_b = (n < 2500) ? 24'hFFFFFF : 24'($urandom);
      #1;

      ea = model(ka, cfg_a, reset_a);
      chk("a_col",   32'(col_a), 32'(ea.col));
      chk("a_row",   32'(row_a), 32'(ea.row));
      chk("a_fs",    32'(fs_a),  32'(ea.fs));
      chk("a_de",    32'(de_a),  32'(ea.de));
      chk("a_hsync", 32'(hs_a),  32'(ea.hs));
      chk("a_vsync", 32'(vs_a),  32'(ea.vs));
      chk("a_rgb",   32'(rgb_a), ea.de ? 32'(prev_a) : 32'(0));
      if (ea.de) chk("a_align", 32'(rgb_a[23:16]), 32'(((ka - A_LAT - 1) % A_HT) % 256));

      eb = model(kb, cfg_b, reset_b);
      chk("b_col",   32'(col_b), 32'(eb.col));
      chk("b_row",   32'(row_b), 32'(eb.row));
      chk("b_fs",    32'(fs_b),  32'(eb.fs));
      chk("b_de",    32'(de_b),  32'(eb.de));
      chk("b_hsync", 32'(hs_b),  32'(!eb.hs));
      chk("b_vsync", 32'(vs_b),  32'(eb.vs));
      chk("b_rgb",   32'(rgb_b), eb.de ? 32'(prev_b) : 32'(0));

      // Hand-derived anchor points for the full-size raster.
      if (ka == 5)    chk("a_lit_de_pre",    32'(de_a), 32'(0));
      if (ka == 6)    chk("a_lit_de_first",  32'(de_a), 32'(1));
      if (ka == 6)    chk("a_lit_red_first", 32'(rgb_a[23:16]), 32'(0));
      if (ka == 133)  chk("a_lit_red_128",   32'(rgb_a[23:16]), 32'(127));
      if (ka == 2013) chk("a_lit_hs_before", 32'(hs_a), 32'(0));
      if (ka == 2014) chk("a_lit_hs_rise",   32'(hs_a), 32'(1));
      if (ka == 2057) chk("a_lit_hs_last",   32'(hs_a), 32'(1));
      if (ka == 2058) chk("a_lit_hs_fall",   32'(hs_a), 32'(0));
      if (ka == 2200) chk("a_lit_line_col",  32'(col_a), 32'(0));
      if (ka == 2200) chk("a_lit_line_row",  32'(row_a), 32'(1));
      if (kb == B_FRAME - 1) chk("b_lit_fs_pre", 32'(fs_b), 32'(0));
      if (kb == B_FRAME)     chk("b_lit_fs",     32'(fs_b), 32'(1));

      // One whole output frame of the small raster: 40x12 DE cycles, 3 lines of vsync.
      if (!b_rst_done && kb >= B_LAT + 1 && kb < B_LAT + 1 + B_FRAME) begin
        if (de_b === 1'b1) b_de_cnt++;
        if (vs_b === 1'b1) b_vs_cnt++;
      end
      if (!b_rst_done && kb == B_LAT + 1 + B_FRAME) begin
        chk("b_lit_de_count", 32'(b_de_cnt), 32'(480));
        chk("b_lit_vs_count", 32'(b_vs_cnt), 32'(174));
      end

      prev_a = color_a;
      prev_b = color_b;
      if (reset_a) begin ka = 0; a_rst_done = 1'b1; end else ka++;
      if (reset_b) begin kb = 0; b_rst_done = 1'b1; end else kb++;
      @(posedge clock); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
